// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: writeback control bit positions, load-kind encodings
// and default datapath widths used by the MEM/WB stage.
package pipeline_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam int REGWRITE = 0;
  localparam int MEMTOREG = 1;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } ld_type_e;

endpackage

// File: rtl/load_extend.sv
// Little-endian byte/halfword select with sign or zero extension; purely combinational.
// Undefined load kinds fall through to the full word, same as LW.
module load_extend
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [2:0]        ld_type,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    data = rdata;
    case (ld_type_e'(ld_type))
      LD_B:    data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_BU:   data = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_H:    data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_HU:   data = {{(DATA_W-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback mux and retire counter; one cycle MEM->WB.
// stall holds the register, flush loads a bubble and wins over stall.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [1:0]        mem_wb,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [2:0]        mem_ld_type,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_misalign,
  output logic [CNT_W-1:0]  retired_count
);

  logic              valid_q, valid_d;
  logic [1:0]        wbc_q, wbc_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [2:0]        ld_q, ld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] ld_data;
  logic              is_half;

  always_comb begin
    valid_d = valid_q;
    wbc_d   = wbc_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    ld_d    = ld_q;
    // Only the control bits matter for a bubble; data fields are left as they were.
    if (flush) begin
      valid_d = 1'b0;
      wbc_d   = 2'b00;
    end else if (!stall) begin
      valid_d = mem_valid;
      wbc_d   = mem_wb;
      alu_d   = mem_alu_result;
      rdata_d = mem_rdata;
      rd_d    = mem_rd;
      ld_d    = mem_ld_type;
    end
  end

  // An entry retires when it leaves the register; a stalled entry has not left yet.
  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, (valid_q & ~stall)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      wbc_q   <= 2'b00;
      alu_q   <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      ld_q    <= 3'b000;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wbc_q   <= wbc_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
    end
  end

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .rdata   (rdata_q),
    .offset  (alu_q[1:0]),
    .ld_type (ld_q),
    .data    (ld_data)
  );

  assign is_half       = (ld_q == LD_H) || (ld_q == LD_HU);
  assign wb_misalign   = valid_q & wbc_q[MEMTOREG] & is_half & alu_q[0];
  assign wb_valid      = valid_q;
  assign wb_rd         = rd_q;
  assign wb_reg_write  = valid_q & wbc_q[REGWRITE] & (rd_q != '0) & ~wb_misalign;
  assign wb_wdata      = wbc_q[MEMTOREG] ? ld_data : alu_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage (CNT_W=4 so the counter wraps quickly),
// checked against a transaction-level model of the MEM/WB register and retire count.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, mem_valid;
  logic [1:0]  mem_wb;
  logic [31:0] mem_alu_result, mem_rdata;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_ld_type;
  logic        wb_valid, wb_reg_write, wb_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic [3:0]  retired_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid;
  logic [1:0]  m_wb;
  logic [31:0] m_alu, m_rdata;
  logic [4:0]  m_rd;
  logic [2:0]  m_ld;
  int          m_cnt;
  bit          m_known;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_wb         (mem_wb),
    .mem_alu_result (mem_alu_result),
    .mem_rdata      (mem_rdata),
    .mem_rd         (mem_rd),
    .mem_ld_type    (mem_ld_type),
    .wb_valid       (wb_valid),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_wdata       (wb_wdata),
    .wb_misalign    (wb_misalign),
    .retired_count  (retired_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load();
    int o;
    logic [31:0] v;
    o = int'(m_alu % 4);
    case (m_ld)
      3'd1, 3'd2: begin
        v = (m_rdata >> (8 * o)) % 256;
        if (m_ld == 3'd1 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'd3, 3'd4: begin
        v = (m_rdata >> (16 * (o / 2))) % 65536;
        if (m_ld == 3'd3 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = m_rdata;
    endcase
    return v;
  endfunction

  function automatic bit model_misalign();
    return m_valid && m_wb[1] && (m_ld == 3'd3 || m_ld == 3'd4) && (m_alu % 2 == 1);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wb = 0; m_alu = 0; m_rdata = 0; m_rd = 0; m_ld = 0;
    m_cnt = 0; m_known = 1;
  endtask

  task automatic check_outputs();
    bit mis;
    mis = model_misalign();
    check_val("wb_valid", {31'b0, wb_valid}, {31'b0, m_valid});
    check_val("wb_rd", {27'b0, wb_rd}, {27'b0, m_rd});
    check_val("wb_misalign", {31'b0, wb_misalign}, {31'b0, mis});
    check_val("wb_reg_write", {31'b0, wb_reg_write},
              {31'b0, m_valid && m_wb[0] && m_rd != 0 && !mis});
    check_val("retired_count", {28'b0, retired_count}, m_cnt);
    if (m_known) check_val("wb_wdata", wb_wdata, m_wb[1] ? model_load() : m_alu);
  endtask

  task automatic step(input bit v, input logic [1:0] wb, input logic [31:0] alu,
                      input logic [31:0] rdata, input logic [4:0] rd, input logic [2:0] ld,
                      input bit st, input bit fl);
    mem_valid = v; mem_wb = wb; mem_alu_result = alu; mem_rdata = rdata;
    mem_rd = rd; mem_ld_type = ld; stall = st; flush = fl;
    @(posedge clk);
    if (m_valid && !st) m_cnt = (m_cnt + 1) % 16;
    if (fl) begin
      m_valid = 0; m_wb = 0; m_known = 0;
    end else if (!st) begin
      m_valid = v; m_wb = wb; m_alu = alu; m_rdata = rdata; m_rd = rd; m_ld = ld;
      m_known = 1;
    end
    #1;
    check_outputs();
  endtask

  task automatic check_reset_zero(input string tag);
    check_val({tag, "_valid"}, {31'b0, wb_valid}, 0);
    check_val({tag, "_regw"}, {31'b0, wb_reg_write}, 0);
    check_val({tag, "_rd"}, {27'b0, wb_rd}, 0);
    check_val({tag, "_wdata"}, wb_wdata, 0);
    check_val({tag, "_mis"}, {31'b0, wb_misalign}, 0);
    check_val({tag, "_cnt"}, {28'b0, retired_count}, 0);
  endtask

  task automatic mid_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_zero(tag);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt_hold;
    int guard;
    logic [31:0] lb_exp [4];
    lb_exp[0] = 32'h0000_0001; lb_exp[1] = 32'h0000_007F;
    lb_exp[2] = 32'hFFFF_FFFF; lb_exp[3] = 32'hFFFF_FF80;

    rst_n = 1'b0; stall = 0; flush = 0; mem_valid = 0; mem_wb = 0;
    mem_alu_result = 0; mem_rdata = 0; mem_rd = 0; mem_ld_type = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_zero("reset");
    rst_n = 1'b1;

    // ALU op writes back one cycle later and retires on the following edge
    step(1, 2'b01, 32'h1234, 0, 5, 3'd0, 0, 0);
    check_val("alu_regw", {31'b0, wb_reg_write}, 1);
    check_val("alu_rd", {27'b0, wb_rd}, 5);
    check_val("alu_wdata", wb_wdata, 32'h0000_1234);
    step(0, 2'b00, 0, 0, 0, 3'd0, 0, 0);
    check_val("alu_cnt", {28'b0, retired_count}, 1);

    for (int k = 0; k < 4; k++) begin
      step(1, 2'b11, 32'h1000 + k, 32'h80FF_7F01, 3, 3'd1, 0, 0);
      check_val($sformatf("lb_off%0d", k), wb_wdata, lb_exp[k]);
    end
    step(1, 2'b11, 32'h1003, 32'h80FF_7F01, 3, 3'd2, 0, 0);
    check_val("lbu_off3", wb_wdata, 32'h0000_0080);

    step(1, 2'b11, 32'h2000, 32'h8001_7FFF, 4, 3'd3, 0, 0);
    check_val("lh_off0", wb_wdata, 32'h0000_7FFF);
    step(1, 2'b11, 32'h2002, 32'h8001_7FFF, 4, 3'd3, 0, 0);
    check_val("lh_off2", wb_wdata, 32'hFFFF_8001);
    step(1, 2'b11, 32'h2001, 32'h8001_7FFF, 4, 3'd3, 0, 0);
    check_val("lh_off1_mis", {31'b0, wb_misalign}, 1);
    check_val("lh_off1_regw", {31'b0, wb_reg_write}, 0);
    cnt_hold = m_cnt;
    step(1, 2'b01, 32'h55, 0, 0, 3'd0, 0, 0);
    check_val("mis_counted", {28'b0, retired_count}, (cnt_hold + 1) % 16);
    check_val("rd0_regw", {31'b0, wb_reg_write}, 0);
    check_val("rd0_valid", {31'b0, wb_valid}, 1);

    // Stall holds a valid entry without counting; flush+stall drops it uncounted
    step(1, 2'b01, 32'hABCD, 0, 7, 3'd0, 0, 0);
    cnt_hold = m_cnt;
    for (int k = 0; k < 3; k++) begin
      step(1, 2'b11, $urandom, $urandom, 5'($urandom), 3'($urandom), 1, 0);
      check_val("stall_wdata", wb_wdata, 32'hABCD);
      check_val("stall_cnt", {28'b0, retired_count}, cnt_hold);
    end
    step(1, 2'b01, 32'h1, 0, 9, 3'd0, 1, 1);
    check_val("flush_valid", {31'b0, wb_valid}, 0);
    check_val("flush_cnt", {28'b0, retired_count}, cnt_hold);

    guard = 0;
    while (m_cnt != 15 && guard < 40) begin
      step(1, 2'b01, $urandom, 0, 5'($urandom), 3'd0, 0, 0);
      guard++;
    end
    check_val("cnt_max", {28'b0, retired_count}, 15);
    step(1, 2'b01, $urandom, 0, 5'($urandom), 3'd0, 0, 0);
    check_val("cnt_wrap", {28'b0, retired_count}, 0);
    step(1, 2'b11, $urandom, $urandom, 5'($urandom), 3'd3, 0, 0);
    mid_reset("midrst");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) mid_reset("rndrst");
      else step(bit'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom),
                3'($urandom), $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
